// File: rtl/instability_sweep_pkg.sv
// Shared types and arithmetic helpers for the instability sweep detectors.
package instability_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StEval,
    StFineInit,
    StFinish
  } state_e;

  typedef enum logic {
    PhCoarse,
    PhFine
  } phase_e;

  // Saturating add; 32-bit operands leave headroom so nothing wraps before the clamp.
  function automatic int unsigned clamp_add(int unsigned a, int unsigned b, int unsigned hi);
    return ((a + b) > hi) ? hi : (a + b);
  endfunction

  // True when stepping a down by step would land below lo.
  function automatic bit step_underflows(int unsigned a, int unsigned step, int unsigned lo);
    return (a < step) || ((a - step) < lo);
  endfunction

endpackage

// File: rtl/instability_sweep_if.sv
// Bus between the sweep controller, the Q measurement front-end and the reference DAC.
interface instability_sweep_if #(
  parameter int unsigned Width = 10
);
  logic             start;
  logic             q_valid;
  logic [Width-1:0] q_measured;
  logic [Width-1:0] i_ref_setup;
  logic             busy;
  logic             done;
  logic             found;
  logic [Width-1:0] i_ref_unstable;

  modport master (
    output start, q_valid, q_measured,
    input  i_ref_setup, busy, done, found, i_ref_unstable
  );

  modport slave (
    input  start, q_valid, q_measured,
    output i_ref_setup, busy, done, found, i_ref_unstable
  );
endinterface

// File: rtl/instability_sweep_settle_timer.sv
// Counts the settle window after each reference change; expired_o marks its last cycle.
module settle_timer #(
  parameter int unsigned Settle = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CntW = (Settle < 2) ? 1 : $clog2(Settle + 1);

  logic [CntW-1:0] cnt_q;

  assign expired_o = (cnt_q == CntW'(Settle - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/instability_sweep.sv
// Sweeps the DAC reference down coarse then fine, locating the point where Q jumps,
// and parks the reference a safety margin above the last stable point.
module instability_sweep
  import instability_pkg::*;
#(
  parameter int unsigned Width      = 10,
  parameter int unsigned Delta      = 300,
  parameter int unsigned CoarseStep = 50,
  parameter int unsigned FineStep   = 5,
  parameter int unsigned Margin     = 10,
  parameter int unsigned Settle     = 4,
  parameter int unsigned IrefMax    = (1 << Width) - 1,
  parameter int unsigned IrefMin    = 0,
  parameter int unsigned AbsMode    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  instability_sweep_if.slave bus
);
  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic             prev_valid_q, prev_valid_d;
  logic [Width-1:0] q_prev_q, q_prev_d;
  logic [Width-1:0] q_new_q, q_new_d;
  logic [Width-1:0] stable_q, stable_d;
  logic [Width-1:0] iref_q, iref_d;
  logic [Width-1:0] unstable_q, unstable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;

  logic             settle_expired;
  logic             settle_load;
  logic [Width:0]   diff;
  logic             jump;
  logic             take_step;
  int unsigned      step;

  assign settle_load = (state_d == StSettle) && (state_q != StSettle);

  settle_timer #(
    .Settle (Settle)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (settle_load),
    .en_i      (state_q == StSettle),
    .expired_o (settle_expired)
  );

  // Magnitude on Width+1 bits; rise-only mode additionally requires q to go up.
  always_comb begin
    if (q_new_q >= q_prev_q) begin
      diff = {1'b0, q_new_q} - {1'b0, q_prev_q};
    end else begin
      diff = {1'b0, q_prev_q} - {1'b0, q_new_q};
    end
    jump = ((AbsMode != 0) || (q_new_q > q_prev_q)) && (32'(diff) > Delta);
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    prev_valid_d = prev_valid_q;
    q_prev_d     = q_prev_q;
    q_new_d      = q_new_q;
    stable_d     = stable_q;
    iref_d       = iref_q;
    unstable_d   = unstable_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    found_d      = found_q;
    take_step    = 1'b0;
    step         = (phase_q == PhCoarse) ? CoarseStep : FineStep;

    unique case (state_q)
      StIdle: begin
        // done_q blocks a start that lands on the completion cycle.
        if (bus.start && !done_q) begin
          iref_d       = Width'(IrefMax);
          found_d      = 1'b0;
          phase_d      = PhCoarse;
          prev_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (settle_expired) state_d = StSample;
      end
      StSample: begin
        if (bus.q_valid) begin
          q_new_d = bus.q_measured;
          state_d = StEval;
        end
      end
      StEval: begin
        if (!prev_valid_q || !jump) begin
          prev_valid_d = 1'b1;
          q_prev_d     = q_new_q;
          stable_d     = iref_q;
          take_step    = 1'b1;
        end else if ((phase_q == PhCoarse) && (FineStep != 0)) begin
          state_d = StFineInit;
        end else begin
          unstable_d = iref_q;
          found_d    = 1'b1;
          state_d    = StFinish;
        end
        if (take_step) begin
          if (step_underflows(32'(iref_q), step, IrefMin)) begin
            state_d = StFinish;
          end else begin
            iref_d  = iref_q - Width'(step);
            state_d = StSettle;
          end
        end
      end
      StFineInit: begin
        phase_d      = PhFine;
        iref_d       = stable_q;
        prev_valid_d = 1'b0;
        state_d      = StSettle;
      end
      StFinish: begin
        iref_d  = found_q ? Width'(clamp_add(32'(stable_q), Margin, IrefMax)) : Width'(IrefMax);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= PhCoarse;
      prev_valid_q <= 1'b0;
      q_prev_q     <= '0;
      q_new_q      <= '0;
      stable_q     <= '0;
      iref_q       <= Width'(IrefMax);
      unstable_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_valid_q <= prev_valid_d;
      q_prev_q     <= q_prev_d;
      q_new_q      <= q_new_d;
      stable_q     <= stable_d;
      iref_q       <= iref_d;
      unstable_q   <= unstable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
    end
  end

  assign bus.i_ref_setup    = iref_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.found          = found_q;
  assign bus.i_ref_unstable = unstable_q;
endmodule

// File: tb/tb_instability_sweep.sv
// Directed bench: a step-plant drives three parameter variants; a sweep model predicts
// every visited reference point and the final result.
module tb_instability_sweep;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instability_sweep_if #(.Width(10)) if0 ();
  instability_sweep_if #(.Width(10)) if1 ();
  instability_sweep_if #(.Width(10)) if2 ();

  instability_sweep u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  instability_sweep #(.AbsMode(1)) u_dut_abs (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  instability_sweep #(.FineStep(0)) u_dut_nf (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int checks = 0;
  int failures = 0;

  int       sel = 0;
  logic     start = 1'b0;
  logic     q_valid_r = 1'b0;
  logic [9:0] q_r = '0;
  int       thr = 600, q_above = 100, q_below = 500;
  bit       glitch = 0;
  int       qv_delay = 0;

  assign if0.start = start && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if2.start = start && (sel == 2);
  assign if0.q_valid = q_valid_r;
  assign if1.q_valid = q_valid_r;
  assign if2.q_valid = q_valid_r;
  assign if0.q_measured = q_r;
  assign if1.q_measured = q_r;
  assign if2.q_measured = q_r;

  logic [9:0] cur_iref, cur_unst;
  logic       cur_busy, cur_done, cur_found;
  always_comb begin
    cur_iref = if0.i_ref_setup; cur_unst = if0.i_ref_unstable;
    cur_busy = if0.busy; cur_done = if0.done; cur_found = if0.found;
    if (sel == 1) begin
      cur_iref = if1.i_ref_setup; cur_unst = if1.i_ref_unstable;
      cur_busy = if1.busy; cur_done = if1.done; cur_found = if1.found;
    end else if (sel == 2) begin
      cur_iref = if2.i_ref_setup; cur_unst = if2.i_ref_unstable;
      cur_busy = if2.busy; cur_done = if2.done; cur_found = if2.found;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int plant(input int i);
    return (i >= thr) ? q_above : q_below;
  endfunction

  // Sweep model: visited points in order plus the final result.
  int exp_pts[$];
  int exp_found = 0, exp_unst = 0, exp_setup = 1023;

  task automatic run_model(input bit abs_mode, input int fine);
    int i, qp, stable, s, q, d;
    bit pv, coarse, jmp;
    exp_pts.delete();
    i = 1023; pv = 0; coarse = 1; stable = 0; qp = 0;
    while (1) begin
      exp_pts.push_back(i);
      q = plant(i);
      d = q - qp;
      jmp = pv && (abs_mode ? (d > 300 || d < -300) : (d > 300));
      if (jmp && coarse && fine > 0) begin
        coarse = 0; pv = 0; i = stable;
        continue;
      end
      if (jmp) begin
        exp_found = 1; exp_unst = i;
        exp_setup = (stable + 10 > 1023) ? 1023 : stable + 10;
        break;
      end
      pv = 1; qp = q; stable = i;
      s = coarse ? 50 : fine;
      if (i - s < 0) begin
        exp_found = 0; exp_setup = 1023;
        break;
      end
      i -= s;
    end
  endtask

  // Compare process plus plant drive, both on the falling edge.
  int hold = 0;
  int last_point = -1;
  logic prev_busy = 1'b0;
  logic [9:0] prev_iref = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0; prev_busy = 1'b0; prev_iref = cur_iref;
    end else begin
      if (cur_busy && (!prev_busy || cur_iref != prev_iref)) begin
        if (prev_busy) chk("point_hold_ge_settle", (hold + 1 >= 4) ? 1 : 0, 1);
        chk("sweep_point", int'(cur_iref), (exp_pts.size() > 0) ? exp_pts.pop_front() : -1);
        last_point = int'(cur_iref);
        hold = 0;
      end else begin
        hold++;
      end
      if (cur_done) begin
        chk("done_found", int'(cur_found), exp_found);
        chk("done_unstable", int'(cur_unst), exp_unst);
        chk("done_setup", int'(cur_iref), exp_setup);
        chk("points_left", exp_pts.size(), 0);
        chk("done_busy_low", int'(cur_busy), 0);
      end
      prev_busy = cur_busy;
      prev_iref = cur_iref;
    end
    q_valid_r = (hold >= qv_delay);
    q_r = (glitch && cur_busy && hold < 4) ? 10'd900 : 10'(plant(int'(cur_iref)));
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep(input int s, input int t, input int qa, input int qb, input bit g,
                       input int qvd, input bit repulse, input bit done_start);
    int n;
    sel = s; thr = t; q_above = qa; q_below = qb; glitch = g; qv_delay = qvd;
    run_model(s == 1, (s == 2) ? 0 : 5);
    @(negedge clk);
    pulse_start();
    if (repulse) begin
      repeat (40) @(negedge clk);
      chk("busy_mid_sweep", int'(cur_busy), 1);
      pulse_start();
    end
    n = 0;
    while (!cur_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(cur_done), 1);
    if (done_start) begin
      pulse_start();
      chk("start_on_done_ignored", int'(cur_busy), 0);
    end
    @(negedge clk);
    chk("done_one_cycle", int'(cur_done), 0);
    glitch = 0; qv_delay = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_iref", int'(cur_iref), 1023);
    chk("rst_busy", int'(cur_busy), 0);
    chk("rst_done", int'(cur_done), 0);
    chk("rst_found", int'(cur_found), 0);
    chk("rst_unstable", int'(cur_unst), 0);
    rst_n = 1'b1;

    // Nominal, delayed q_valid, restart attempt while busy and on the done cycle.
    sweep(0, 600, 100, 500, 0, 6, 1, 1);
    chk("t2_unstable", int'(cur_unst), 598);
    chk("t2_setup", int'(cur_iref), 613);
    chk("t2_found", int'(cur_found), 1);

    // Asynchronous reset mid-sweep.
    run_model(0, 5);
    @(negedge clk);
    pulse_start();
    repeat (60) @(negedge clk);
    chk("t1_midsweep_moved", (cur_iref != 10'd1023) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_iref", int'(cur_iref), 1023);
    chk("t1_busy", int'(cur_busy), 0);
    chk("t1_found", int'(cur_found), 0);
    chk("t1_unstable", int'(cur_unst), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_idle_busy", int'(cur_busy), 0);
    chk("t1_idle_done", int'(cur_done), 0);

    // Settle window: q=900 offered during settling must be ignored.
    sweep(0, 600, 100, 500, 1, 0, 0, 0);
    chk("t4_unstable", int'(cur_unst), 598);
    chk("t4_setup", int'(cur_iref), 613);

    // No instability.
    sweep(0, 0, 100, 100, 0, 0, 0, 0);
    chk("t3_found", int'(cur_found), 0);
    chk("t3_setup", int'(cur_iref), 1023);
    chk("t3_last_point", last_point, 23);

    // Falling Q: absolute mode detects it, rise-only mode does not.
    sweep(1, 600, 600, 100, 0, 0, 0, 0);
    chk("t5_abs_found", int'(cur_found), 1);
    chk("t5_abs_unstable", int'(cur_unst), 598);
    sweep(0, 600, 600, 100, 0, 0, 0, 0);
    chk("t5_rise_found", int'(cur_found), 0);

    // No fine phase.
    sweep(2, 600, 100, 500, 0, 0, 0, 0);
    chk("t6_nofine_unstable", int'(cur_unst), 573);
    chk("t6_nofine_setup", int'(cur_iref), 633);

    // Margin clamps at full scale.
    sweep(0, 1020, 100, 500, 0, 0, 0, 0);
    chk("t6_clamp_unstable", int'(cur_unst), 1018);
    chk("t6_clamp_setup", int'(cur_iref), 1023);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
